// File: rtl/perips_wb_arbiter_pkg.sv
// Shared definitions for the peripheral-bus Wishbone arbiter.
//   - Bus widths: address, data and byte-select.
//   - Default watchdog length used when the arbiter is instantiated.
//   - Arbiter state encodings.
//   - Debug struct that exposes the FSM state and its held registers.
package perips_wb_arbiter_pkg;

   localparam int WB_AD_WIDTH         = 32;
   localparam int WB_DAT_WIDTH        = 32;
   localparam int WB_SEL_WIDTH        = WB_DAT_WIDTH / 8;
   localparam int ARB_TIMEOUT_DEFAULT = 16;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      arb_state_t state;
      logic       grant;
      logic       last;
      logic [7:0] tmo_cnt;
   } arb_dbg_t;

endpackage

// File: rtl/perips_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req[1:0]  : request lines, bit i = master i
//   last      : index of the master served most recently
//   gnt_valid : at least one request present
//   gnt_idx   : chosen master; on a tie the master that was not served last
module perips_rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      // A single requester wins outright; req[1] alone selects master 1.
      gnt_idx   = (req == 2'b11) ? ~last : req[1];
   end

endmodule

// File: rtl/perips_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the shared peripheral bus.
// m0 is the core LSU, m1 the host/debug master. Grant is round-robin and is
// held for one complete transaction. A watchdog answers with a one-cycle
// error pulse when the addressed peripheral never acks.
//
// Handshake: a master requests with cyc & stb. While granted, its cyc/stb
// are forwarded to the slave; the transaction ends on s_ack_i (ack to the
// master, rdata passed through the same cycle), on the master dropping cyc
// (silent abandon) or on the watchdog (err pulse, slave cyc/stb forced low).
// The arbiter always spends one IDLE cycle between transactions.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m{0,1}_*_i               master cyc/stb/we/addr/wdata/sel
//   m{0,1}_rdata_o/ack_o/err_o  responses, zero unless addressed to that master
//   s_*_o                    forwarded request to the peripheral bus
//   s_rdata_i, s_ack_i       peripheral response
//   dbg                      FSM state, grant, last and watchdog count
module perips_wb_arbiter
   import perips_wb_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m0_cyc_i,
   input  logic                    m0_stb_i,
   input  logic                    m0_we_i,
   input  logic [WB_AD_WIDTH-1:0]  m0_addr_i,
   input  logic [WB_DAT_WIDTH-1:0] m0_wdata_i,
   input  logic [WB_SEL_WIDTH-1:0] m0_sel_i,
   output logic [WB_DAT_WIDTH-1:0] m0_rdata_o,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,
   input  logic                    m1_cyc_i,
   input  logic                    m1_stb_i,
   input  logic                    m1_we_i,
   input  logic [WB_AD_WIDTH-1:0]  m1_addr_i,
   input  logic [WB_DAT_WIDTH-1:0] m1_wdata_i,
   input  logic [WB_SEL_WIDTH-1:0] m1_sel_i,
   output logic [WB_DAT_WIDTH-1:0] m1_rdata_o,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [WB_AD_WIDTH-1:0]  s_addr_o,
   output logic [WB_DAT_WIDTH-1:0] s_wdata_o,
   output logic [WB_SEL_WIDTH-1:0] s_sel_o,
   input  logic [WB_DAT_WIDTH-1:0] s_rdata_i,
   input  logic                    s_ack_i,
   output arb_dbg_t                dbg
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   arb_state_t state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_q, last_d;
   logic [7:0] tmo_q, tmo_d;

   logic [1:0] req;
   logic       pick_valid, pick_idx;
   logic       g_cyc, g_stb, ack_hit, tmo_hit;

   assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

   perips_rr_pick2 u_pick (
      .req       (req),
      .last      (last_q),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         tmo_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      tmo_d      = tmo_q;
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      s_we_o     = 1'b0;
      s_addr_o   = '0;
      s_wdata_o  = '0;
      s_sel_o    = '0;
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_rdata_o = '0;
      m1_ack_o   = 1'b0;
      m1_err_o   = 1'b0;
      m1_rdata_o = '0;

      g_cyc   = grant_q ? m1_cyc_i : m0_cyc_i;
      g_stb   = grant_q ? m1_stb_i : m0_stb_i;
      ack_hit = 1'b0;
      tmo_hit = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = ARB_BUSY;
               grant_d = pick_idx;
               tmo_d   = 8'd0;
            end
         end
         ARB_BUSY: begin
            ack_hit = s_ack_i & g_cyc;
            // Ack wins over the watchdog; an abandoned cycle never errors.
            tmo_hit = g_cyc & ~ack_hit & (tmo_q == TMO_LAST);

            s_cyc_o   = g_cyc & ~tmo_hit;
            s_stb_o   = g_stb & ~tmo_hit;
            s_we_o    = grant_q ? m1_we_i    : m0_we_i;
            s_addr_o  = grant_q ? m1_addr_i  : m0_addr_i;
            s_wdata_o = grant_q ? m1_wdata_i : m0_wdata_i;
            s_sel_o   = grant_q ? m1_sel_i   : m0_sel_i;

            if (grant_q) begin
               m1_ack_o   = ack_hit;
               m1_err_o   = tmo_hit;
               m1_rdata_o = ack_hit ? s_rdata_i : '0;
            end else begin
               m0_ack_o   = ack_hit;
               m0_err_o   = tmo_hit;
               m0_rdata_o = ack_hit ? s_rdata_i : '0;
            end

            if (!g_cyc || ack_hit || tmo_hit) begin
               state_d = ARB_IDLE;
               last_d  = grant_q;
               tmo_d   = 8'd0;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign dbg = '{state: state_q, grant: grant_q, last: last_q, tmo_cnt: tmo_q};

endmodule

// File: tb/tb_perips_wb_arbiter.sv
// Directed bench for perips_wb_arbiter with a four-cycle watchdog.
// Inputs are driven 2 time units after each rising edge and outputs are
// checked 1 unit later, mid-cycle.
module tb_perips_wb_arbiter;
   import perips_wb_arbiter_pkg::*;

   localparam logic [31:0] A0 = 32'h0200_4000;  // CLINT MTIMECMP low
   localparam logic [31:0] A1 = 32'h0200_BFF8;  // CLINT MTIME low
   localparam logic [31:0] AU = 32'h0200_0100;  // unmapped CLINT offset

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
   logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
   logic [3:0]  m0_sel_i = '0;
   logic [31:0] m0_rdata_o;
   logic        m0_ack_o, m0_err_o;
   logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
   logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
   logic [3:0]  m1_sel_i = '0;
   logic [31:0] m1_rdata_o;
   logic        m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [31:0] s_addr_o, s_wdata_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_rdata_i = '0;
   logic        s_ack_i = 1'b0;
   arb_dbg_t    dbg;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   perips_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
      .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i),
      .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
      .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i),
      .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
      .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .dbg(dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic m0_drive(input logic on, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
      m0_cyc_i = on; m0_stb_i = on; m0_addr_i = a; m0_we_i = w;
      m0_wdata_i = d; m0_sel_i = s;
   endtask

   task automatic m1_drive(input logic on, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
      m1_cyc_i = on; m1_stb_i = on; m1_addr_i = a; m1_we_i = w;
      m1_wdata_i = d; m1_sel_i = s;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_s_cyc"}, {31'd0, s_cyc_o}, 32'd0);
      chk({tag, "_s_stb"}, {31'd0, s_stb_o}, 32'd0);
      chk({tag, "_m0_ack"}, {31'd0, m0_ack_o}, 32'd0);
      chk({tag, "_m0_err"}, {31'd0, m0_err_o}, 32'd0);
      chk({tag, "_m1_ack"}, {31'd0, m1_ack_o}, 32'd0);
      chk({tag, "_m1_err"}, {31'd0, m1_err_o}, 32'd0);
      chk({tag, "_m0_rdata"}, m0_rdata_o, 32'd0);
      chk({tag, "_m1_rdata"}, m1_rdata_o, 32'd0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset: outputs quiet even with m0 requesting during reset.
      m0_drive(1, A0, 0, 32'h0, 4'hF);
      tick(); #1;
      chk_quiet("reset");
      chk("reset_last", {31'd0, dbg.last}, 32'd1);
      chk("reset_state", {31'd0, dbg.state}, 32'd0);
      chk("reset_tmo", {24'd0, dbg.tmo_cnt}, 32'd0);
      tick(); rst = 0; m0_drive(0, 0, 0, 0, 0); #1;

      // Single m0 read of MTIMECMP low.
      tick(); m0_drive(1, A0, 0, 32'h0, 4'hF); #1;
      chk("rd_T_s_cyc", {31'd0, s_cyc_o}, 32'd0);
      tick(); #1;
      chk("rd_T1_s_stb", {31'd0, s_stb_o}, 32'd1);
      chk("rd_T1_s_addr", s_addr_o, A0);
      chk("rd_T1_s_we", {31'd0, s_we_o}, 32'd0);
      chk("rd_T1_m0_ack", {31'd0, m0_ack_o}, 32'd0);
      tick(); s_ack_i = 1; s_rdata_i = 32'h0000_FFFF; #1;
      chk("rd_T2_m0_ack", {31'd0, m0_ack_o}, 32'd1);
      chk("rd_T2_m0_rdata", m0_rdata_o, 32'h0000_FFFF);
      chk("rd_T2_m1_ack", {31'd0, m1_ack_o}, 32'd0);
      chk("rd_T2_m1_rdata", m1_rdata_o, 32'd0);
      tick(); s_ack_i = 0; s_rdata_i = 0; m0_drive(0, 0, 0, 0, 0); #1;
      chk("rd_T3_state", {31'd0, dbg.state}, 32'd0);
      chk_quiet("rd_T3");
      chk("rd_T3_last", {31'd0, dbg.last}, 32'd0);

      // Tie right after reset: m0 first, then m1; last goes 1 -> 0 -> 1.
      tick(); rst = 1; tick(); rst = 0; #1;
      chk("tie_reset_last", {31'd0, dbg.last}, 32'd1);
      tick(); m0_drive(1, A0, 0, 0, 4'hF); m1_drive(1, A1, 0, 0, 4'hF); #1;
      tick(); #1;
      chk("tie_grant0_addr", s_addr_o, A0);
      tick(); s_ack_i = 1; s_rdata_i = 32'h1111_0000; #1;
      chk("tie_m0_ack", {31'd0, m0_ack_o}, 32'd1);
      chk("tie_m0_rdata", m0_rdata_o, 32'h1111_0000);
      chk("tie_m1_ack_low", {31'd0, m1_ack_o}, 32'd0);
      chk("tie_m1_rdata_low", m1_rdata_o, 32'd0);
      tick(); s_ack_i = 0; s_rdata_i = 0; m0_drive(0, 0, 0, 0, 0); #1;
      chk("tie_idle_s_cyc", {31'd0, s_cyc_o}, 32'd0);
      chk("tie_last_0", {31'd0, dbg.last}, 32'd0);
      tick(); #1;
      chk("tie_grant1_addr", s_addr_o, A1);
      chk("tie_grant1_cyc", {31'd0, s_cyc_o}, 32'd1);
      chk("tie_grant1_dbg", {31'd0, dbg.grant}, 32'd1);
      tick(); s_ack_i = 1; s_rdata_i = 32'h2222_0000; #1;
      chk("tie_m1_ack", {31'd0, m1_ack_o}, 32'd1);
      chk("tie_m1_rdata", m1_rdata_o, 32'h2222_0000);
      chk("tie_m0_ack_low", {31'd0, m0_ack_o}, 32'd0);
      chk("tie_m0_rdata_low", m0_rdata_o, 32'd0);
      tick(); s_ack_i = 0; s_rdata_i = 0; m1_drive(0, 0, 0, 0, 0); #1;
      chk("tie_last_1", {31'd0, dbg.last}, 32'd1);

      // m0 holds its request; m1 requests once. Grants: m0, m1, m0.
      tick(); m0_drive(1, A0, 0, 0, 4'hF); m1_drive(1, A1, 0, 0, 4'hF); #1;
      tick(); #1;
      chk("alt_1_addr", s_addr_o, A0);
      tick(); s_ack_i = 1; s_rdata_i = 32'h3; #1;
      chk("alt_1_m0_ack", {31'd0, m0_ack_o}, 32'd1);
      tick(); s_ack_i = 0; s_rdata_i = 0; #1;
      chk("alt_idle1_s_cyc", {31'd0, s_cyc_o}, 32'd0);
      tick(); #1;
      chk("alt_2_addr", s_addr_o, A1);
      tick(); s_ack_i = 1; s_rdata_i = 32'h4; #1;
      chk("alt_2_m1_ack", {31'd0, m1_ack_o}, 32'd1);
      chk("alt_2_m0_ack", {31'd0, m0_ack_o}, 32'd0);
      tick(); s_ack_i = 0; s_rdata_i = 0; m1_drive(0, 0, 0, 0, 0); #1;
      tick(); #1;
      chk("alt_3_addr", s_addr_o, A0);
      chk("alt_3_grant", {31'd0, dbg.grant}, 32'd0);
      tick(); s_ack_i = 1; s_rdata_i = 32'h5; #1;
      chk("alt_3_m0_ack", {31'd0, m0_ack_o}, 32'd1);
      tick(); s_ack_i = 0; s_rdata_i = 0; m0_drive(0, 0, 0, 0, 0); #1;
      chk("alt_last", {31'd0, dbg.last}, 32'd0);

      // m1 write to an unmapped offset: err on the 4th cycle of the grant.
      tick(); m1_drive(1, AU, 1, 32'hCAFE_0001, 4'b0011); #1;
      tick(); #1;
      chk("tmo_c1_s_cyc", {31'd0, s_cyc_o}, 32'd1);
      chk("tmo_c1_s_we", {31'd0, s_we_o}, 32'd1);
      chk("tmo_c1_wdata", s_wdata_o, 32'hCAFE_0001);
      chk("tmo_c1_sel", {28'd0, s_sel_o}, 32'h3);
      chk("tmo_c1_err", {31'd0, m1_err_o}, 32'd0);
      tick(); #1;
      chk("tmo_c2_err", {31'd0, m1_err_o}, 32'd0);
      tick(); #1;
      chk("tmo_c3_err", {31'd0, m1_err_o}, 32'd0);
      chk("tmo_c3_cnt", {24'd0, dbg.tmo_cnt}, 32'd2);
      tick(); s_rdata_i = 32'hDEAD_BEEF; #1;
      chk("tmo_c4_err", {31'd0, m1_err_o}, 32'd1);
      chk("tmo_c4_s_cyc", {31'd0, s_cyc_o}, 32'd0);
      chk("tmo_c4_s_stb", {31'd0, s_stb_o}, 32'd0);
      chk("tmo_c4_m1_ack", {31'd0, m1_ack_o}, 32'd0);
      chk("tmo_c4_m1_rdata", m1_rdata_o, 32'd0);
      chk("tmo_c4_m0_err", {31'd0, m0_err_o}, 32'd0);
      tick(); s_rdata_i = 0; m1_drive(0, 0, 0, 0, 0); m0_drive(1, A0, 0, 0, 4'hF); #1;
      chk_quiet("tmo_after");
      tick(); #1;
      chk("tmo_m0_addr", s_addr_o, A0);
      chk("tmo_m0_cyc", {31'd0, s_cyc_o}, 32'd1);
      tick(); s_ack_i = 1; s_rdata_i = 32'h6; #1;
      chk("tmo_m0_ack", {31'd0, m0_ack_o}, 32'd1);
      chk("tmo_m1_ack", {31'd0, m1_ack_o}, 32'd0);
      tick(); s_ack_i = 0; s_rdata_i = 0; m0_drive(0, 0, 0, 0, 0); #1;

      // Ack on the watchdog's final cycle: ack wins.
      tick(); m0_drive(1, A0, 0, 0, 4'hF); #1;
      tick(); #1;
      tick(); #1;
      tick(); #1;
      chk("race_c3_ack", {31'd0, m0_ack_o}, 32'd0);
      tick(); s_ack_i = 1; s_rdata_i = 32'h5A5A_A5A5; #1;
      chk("race_ack", {31'd0, m0_ack_o}, 32'd1);
      chk("race_err", {31'd0, m0_err_o}, 32'd0);
      chk("race_s_cyc", {31'd0, s_cyc_o}, 32'd1);
      chk("race_rdata", m0_rdata_o, 32'h5A5A_A5A5);
      tick(); s_ack_i = 0; s_rdata_i = 0; m0_drive(0, 0, 0, 0, 0); #1;
      chk("race_idle", {31'd0, dbg.state}, 32'd0);

      // Reset during m0's BUSY, then a fresh m1 request.
      tick(); m0_drive(1, A0, 0, 0, 4'hF); #1;
      tick(); #1;
      chk("rstb_busy_cyc", {31'd0, s_cyc_o}, 32'd1);
      rst = 1;
      tick(); #1;
      chk_quiet("rstb_after_edge");
      chk("rstb_state", {31'd0, dbg.state}, 32'd0);
      chk("rstb_last", {31'd0, dbg.last}, 32'd1);
      rst = 0; m0_drive(0, 0, 0, 0, 0);
      tick(); m1_drive(1, A1, 0, 0, 4'hF); #1;
      chk_quiet("rstb_idle");
      tick(); #1;
      chk("rstb_m1_addr", s_addr_o, A1);
      chk("rstb_m1_cyc", {31'd0, s_cyc_o}, 32'd1);
      tick(); s_ack_i = 1; s_rdata_i = 32'h7; #1;
      chk("rstb_m1_ack", {31'd0, m1_ack_o}, 32'd1);
      chk("rstb_m1_rdata", m1_rdata_o, 32'h7);
      tick(); s_ack_i = 0; s_rdata_i = 0; m1_drive(0, 0, 0, 0, 0); #1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
